id_ex_stage: RTL and testbench

//  Decode->execute pipeline register sitting directly downstream of RegMem. Latches register

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths and the control-bundle bit map used by ID/EX.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_AW = 3;
  localparam int unsigned CTRL_W     = 8;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_LBI      = 3;
  localparam int unsigned CTRL_LINK     = 4;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_ALUOP_LO = 6;
  localparam int unsigned CTRL_ALUOP_HI = 7;

  // A load is anything that both reads memory and writes the register file.
  function automatic logic is_load(input logic memread, input logic regwrite);
    return memread & regwrite;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the decode slot and the instruction held in EX.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rs_used_i,
  input  logic              rt_used_i,
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic              ex_regwrite_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              hazard_o
);

  logic src_match;

  always_comb begin
    src_match = (rs_used_i & (rs_i == ex_rd_i)) | (rt_used_i & (rt_i == ex_rd_i));
    hazard_o  = id_valid_i & ex_valid_i & is_load(ex_memread_i, ex_regwrite_i) & src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with load-use bubble insertion, writeback bypass,
// stall/flush handling and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rt,
  input  logic              RsUsed,
  input  logic              RtUsed,
  input  logic [REG_AW-1:0] Rd,
  input  logic [DATA_W-1:0] Reg1Data,
  input  logic [DATA_W-1:0] Reg2Data,
  input  logic [DATA_W-1:0] Imm,
  input  logic [DATA_W-1:0] PC,
  input  logic [CTRL_W-1:0] Ctrl,
  input  logic              WbEn,
  input  logic [REG_AW-1:0] WbReg,
  input  logic [DATA_W-1:0] WbData,
  input  logic              ExStall,
  input  logic              Flush,
  output logic              ExValid,
  output logic [REG_AW-1:0] ExRs,
  output logic [REG_AW-1:0] ExRt,
  output logic [REG_AW-1:0] ExRd,
  output logic [DATA_W-1:0] ExReg1,
  output logic [DATA_W-1:0] ExReg2,
  output logic [DATA_W-1:0] ExImm,
  output logic [DATA_W-1:0] ExPc,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic              IdStall,
  output logic [CNT_W-1:0]  BubbleCnt
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_valid_i   (IdValid),
    .rs_i         (Rs),
    .rt_i         (Rt),
    .rs_used_i    (RsUsed),
    .rt_used_i    (RtUsed),
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_regwrite_i(ctrl_q[CTRL_REGWRITE]),
    .ex_rd_i      (rd_q),
    .hazard_o     (hazard)
  );

  always_comb begin
    IdStall = ~rst & ~Flush & (ExStall | hazard);
  end

  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      valid_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      reg1_d  = '0;
      reg2_d  = '0;
      imm_d   = '0;
      pc_d    = '0;
      ctrl_d  = '0;
    end else if (ExStall) begin
      // Keep held operands fresh so a long stall cannot outlive the producer's writeback.
      if (valid_q && WbEn && (WbReg == rs_q)) reg1_d = WbData;
      if (valid_q && WbEn && (WbReg == rt_q)) reg2_d = WbData;
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d = IdValid;
      ctrl_d  = IdValid ? Ctrl : '0;
      rs_d    = Rs;
      rt_d    = Rt;
      rd_d    = Rd;
      imm_d   = Imm;
      pc_d    = PC;
      reg1_d  = (WbEn && (WbReg == Rs)) ? WbData : Reg1Data;
      reg2_d  = (WbEn && (WbReg == Rt)) ? WbData : Reg2Data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ExValid   = valid_q;
  assign ExRs      = rs_q;
  assign ExRt      = rt_q;
  assign ExRd      = rd_q;
  assign ExReg1    = reg1_q;
  assign ExReg2    = reg2_q;
  assign ExImm     = imm_q;
  assign ExPc      = pc_q;
  assign ExCtrl    = ctrl_q;
  assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table-driven capture/bypass vectors plus hand-written
// hazard, stall, flush, saturation and reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IdValid, RsUsed, RtUsed, WbEn, ExStall, Flush;
  logic [2:0]  Rs, Rt, Rd, WbReg;
  logic [15:0] Reg1Data, Reg2Data, Imm, PC, WbData;
  logic [7:0]  Ctrl;

  logic        ExValid, IdStall;
  logic [2:0]  ExRs, ExRt, ExRd;
  logic [15:0] ExReg1, ExReg2, ExImm, ExPc, BubbleCnt;
  logic [7:0]  ExCtrl;

  // Narrow-counter copy driven by the same stimulus, used to reach saturation quickly.
  logic        s_ExValid, s_IdStall;
  logic [2:0]  s_ExRs, s_ExRt, s_ExRd;
  logic [15:0] s_ExReg1, s_ExReg2, s_ExImm, s_ExPc;
  logic [7:0]  s_ExCtrl;
  logic [3:0]  s_BubbleCnt;

  int tests  = 0;
  int failed = 0;
  int exp_bub = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .IdValid(IdValid), .Rs(Rs), .Rt(Rt), .RsUsed(RsUsed),
    .RtUsed(RtUsed), .Rd(Rd), .Reg1Data(Reg1Data), .Reg2Data(Reg2Data), .Imm(Imm), .PC(PC),
    .Ctrl(Ctrl), .WbEn(WbEn), .WbReg(WbReg), .WbData(WbData), .ExStall(ExStall),
    .Flush(Flush), .ExValid(ExValid), .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd),
    .ExReg1(ExReg1), .ExReg2(ExReg2), .ExImm(ExImm), .ExPc(ExPc), .ExCtrl(ExCtrl),
    .IdStall(IdStall), .BubbleCnt(BubbleCnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .IdValid(IdValid), .Rs(Rs), .Rt(Rt), .RsUsed(RsUsed),
    .RtUsed(RtUsed), .Rd(Rd), .Reg1Data(Reg1Data), .Reg2Data(Reg2Data), .Imm(Imm), .PC(PC),
    .Ctrl(Ctrl), .WbEn(WbEn), .WbReg(WbReg), .WbData(WbData), .ExStall(ExStall),
    .Flush(Flush), .ExValid(s_ExValid), .ExRs(s_ExRs), .ExRt(s_ExRt), .ExRd(s_ExRd),
    .ExReg1(s_ExReg1), .ExReg2(s_ExReg2), .ExImm(s_ExImm), .ExPc(s_ExPc), .ExCtrl(s_ExCtrl),
    .IdStall(s_IdStall), .BubbleCnt(s_BubbleCnt)
  );

  typedef struct {
    logic        idv;
    logic [2:0]  rs, rt, rd;
    logic [15:0] r1, r2, imm, pc;
    logic [7:0]  ctrl;
    logic        wben;
    logic [2:0]  wbreg;
    logic [15:0] wbdata;
    logic        e_valid;
    logic [15:0] e_r1, e_r2;
    logic [7:0]  e_ctrl;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic idv, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                          input logic [7:0] ctrl);
    IdValid = idv; Rs = rs; RsUsed = rsu; Rt = rt; RtUsed = rtu; Rd = rd; Ctrl = ctrl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            idv rs rt rd r1       r2       imm      pc       ctrl   wb wbr wbdata
    //            ev  e_r1     e_r2     e_ctrl
    vecs[0] = '{1, 1, 2, 3, 16'h0011, 16'h0022, 16'd5, 16'd10, 8'h41, 0, 0, 16'h0000,
                1, 16'h0011, 16'h0022, 8'h41};
    vecs[1] = '{1, 1, 2, 4, 16'h0001, 16'h0002, 16'd7, 16'd12, 8'h01, 1, 2, 16'hBEEF,
                1, 16'h0001, 16'hBEEF, 8'h01};
    vecs[2] = '{1, 1, 2, 4, 16'h0001, 16'h0002, 16'd7, 16'd12, 8'h01, 1, 4, 16'hBEEF,
                1, 16'h0001, 16'h0002, 8'h01};
    vecs[3] = '{1, 5, 5, 6, 16'h0101, 16'h0202, 16'd1, 16'd14, 8'hC5, 1, 5, 16'hCAFE,
                1, 16'hCAFE, 16'hCAFE, 8'hC5};
    vecs[4] = '{1, 5, 5, 6, 16'h0101, 16'h0202, 16'd1, 16'd16, 8'h04, 0, 5, 16'hCAFE,
                1, 16'h0101, 16'h0202, 8'h04};
    vecs[5] = '{0, 2, 3, 7, 16'hAAAA, 16'hBBBB, 16'd2, 16'd18, 8'hFF, 0, 0, 16'h0000,
                0, 16'hAAAA, 16'hBBBB, 8'h00};
    vecs[6] = '{1, 0, 1, 2, 16'h1000, 16'h2000, 16'd3, 16'd20, 8'h10, 1, 0, 16'h5555,
                1, 16'h5555, 16'h2000, 8'h10};

    // Reset with arbitrary inputs, stall requested: nothing may leak through.
    rst = 1; WbEn = 1; WbReg = 3'($urandom); WbData = 16'($urandom); ExStall = 1; Flush = 0;
    drive_id(1, 3'($urandom), 1, 3'($urandom), 1, 3'($urandom), 8'h03);
    Reg1Data = 16'($urandom); Reg2Data = 16'($urandom); Imm = 16'($urandom); PC = 16'($urandom);
    repeat (2) cyc();
    chk("rst_valid", ExValid, 0);
    chk("rst_ctrl", ExCtrl, 0);
    chk("rst_reg1", ExReg1, 0);
    chk("rst_reg2", ExReg2, 0);
    chk("rst_imm", ExImm, 0);
    chk("rst_pc", ExPc, 0);
    chk("rst_rd", ExRd, 0);
    chk("rst_idstall", IdStall, 0);
    chk("rst_bubble", BubbleCnt, 0);
    rst = 0; ExStall = 0;

    foreach (vecs[i]) begin
      drive_id(vecs[i].idv, vecs[i].rs, 1, vecs[i].rt, 1, vecs[i].rd, vecs[i].ctrl);
      Reg1Data = vecs[i].r1; Reg2Data = vecs[i].r2; Imm = vecs[i].imm; PC = vecs[i].pc;
      WbEn = vecs[i].wben; WbReg = vecs[i].wbreg; WbData = vecs[i].wbdata;
      #1 chk($sformatf("v%0d_idstall", i), IdStall, 0);
      cyc();
      chk($sformatf("v%0d_valid", i), ExValid, vecs[i].e_valid);
      chk($sformatf("v%0d_reg1", i), ExReg1, vecs[i].e_r1);
      chk($sformatf("v%0d_reg2", i), ExReg2, vecs[i].e_r2);
      chk($sformatf("v%0d_ctrl", i), ExCtrl, vecs[i].e_ctrl);
      chk($sformatf("v%0d_imm", i), ExImm, vecs[i].imm);
      chk($sformatf("v%0d_pc", i), ExPc, vecs[i].pc);
      chk($sformatf("v%0d_rd", i), ExRd, vecs[i].rd);
      chk($sformatf("v%0d_rs", i), ExRs, vecs[i].rs);
    end
    WbEn = 0;

    // Load-use on Rs: one bubble, then the dependent instruction is captured.
    drive_id(1, 0, 0, 0, 0, 3, 8'h03);
    cyc();
    chk("ld_valid", ExValid, 1);
    drive_id(1, 3, 1, 6, 1, 5, 8'h01);
    #1 chk("hz_idstall", IdStall, 1);
    cyc();
    exp_bub++;
    chk("hz_valid", ExValid, 0);
    chk("hz_ctrl", ExCtrl, 0);
    chk("hz_bubble", BubbleCnt, exp_bub);
    chk("hz_idstall_drop", IdStall, 0);
    cyc();
    chk("hz_cap_valid", ExValid, 1);
    chk("hz_cap_rd", ExRd, 5);
    chk("hz_cap_ctrl", ExCtrl, 8'h01);

    // Same registers but not used: no bubble.
    drive_id(1, 0, 0, 0, 0, 3, 8'h03);
    cyc();
    drive_id(1, 3, 0, 3, 0, 6, 8'h01);
    #1 chk("nouse_idstall", IdStall, 0);
    cyc();
    chk("nouse_valid", ExValid, 1);
    chk("nouse_rd", ExRd, 6);
    chk("nouse_bubble", BubbleCnt, exp_bub);

    // Non-load producer in EX never stalls.
    drive_id(1, 6, 1, 6, 1, 2, 8'h01);
    #1 chk("noload_idstall", IdStall, 0);
    cyc();

    // Load-use on Rt.
    drive_id(1, 0, 0, 0, 0, 3, 8'h03);
    cyc();
    drive_id(1, 0, 0, 3, 1, 1, 8'h01);
    #1 chk("hzrt_idstall", IdStall, 1);
    cyc();
    exp_bub++;
    chk("hzrt_bubble", BubbleCnt, exp_bub);
    cyc();
    chk("hzrt_cap_rd", ExRd, 1);

    // Long stall with writeback refresh of the held Rs operand.
    drive_id(1, 1, 1, 2, 1, 4, 8'h01);
    Reg1Data = 16'h1111; Reg2Data = 16'h2222; Imm = 16'd9; PC = 16'd20;
    cyc();
    ExStall = 1;
    drive_id(1, 7, 1, 7, 1, 0, 8'h40);
    Reg1Data = 16'hDEAD; Reg2Data = 16'hDEAD; Imm = 16'd99; PC = 16'd99;
    #1 chk("st1_idstall", IdStall, 1);
    cyc();
    chk("st1_reg1", ExReg1, 16'h1111);
    chk("st1_pc", ExPc, 20);
    chk("st2_idstall", IdStall, 1);
    WbEn = 1; WbReg = 1; WbData = 16'h1234;
    cyc();
    chk("st2_reg1", ExReg1, 16'h1234);
    chk("st2_reg2", ExReg2, 16'h2222);
    chk("st3_idstall", IdStall, 1);
    WbEn = 0;
    cyc();
    chk("st3_reg1", ExReg1, 16'h1234);
    chk("st3_imm", ExImm, 9);
    chk("st3_rd", ExRd, 4);
    chk("st3_valid", ExValid, 1);
    ExStall = 0;
    cyc();
    chk("st_rel_rs", ExRs, 7);
    chk("st_rel_pc", ExPc, 99);

    // Stall plus hazard holds without counting; then flush beats both.
    drive_id(1, 0, 0, 0, 0, 3, 8'h03);
    cyc();
    drive_id(1, 3, 1, 0, 0, 5, 8'h01);
    ExStall = 1;
    #1 chk("sh_idstall", IdStall, 1);
    cyc();
    chk("sh_valid", ExValid, 1);
    chk("sh_ctrl", ExCtrl, 8'h03);
    chk("sh_bubble", BubbleCnt, exp_bub);
    Flush = 1;
    #1 chk("fl_idstall", IdStall, 0);
    cyc();
    chk("fl_valid", ExValid, 0);
    chk("fl_ctrl", ExCtrl, 0);
    chk("fl_rd", ExRd, 0);
    chk("fl_bubble", BubbleCnt, exp_bub);
    Flush = 0; ExStall = 0;

    // Self-dependent load repeated: one bubble every other cycle; narrow counter saturates.
    drive_id(1, 3, 1, 0, 0, 3, 8'h03);
    repeat (40) cyc();
    exp_bub += 20;
    chk("sat_bubble", BubbleCnt, exp_bub);
    chk("sat_small", s_BubbleCnt, (exp_bub > 15) ? 15 : exp_bub);
    repeat (2) cyc();
    exp_bub++;
    chk("sat_bubble2", BubbleCnt, exp_bub);
    chk("sat_small2", s_BubbleCnt, 4'hF);

    // Reset in the middle of a stall, then a normal capture.
    drive_id(1, 1, 1, 2, 1, 2, 8'h81);
    ExStall = 1; rst = 1;
    cyc();
    chk("rms_valid", ExValid, 0);
    chk("rms_bubble", BubbleCnt, 0);
    chk("rms_small", s_BubbleCnt, 0);
    chk("rms_idstall", IdStall, 0);
    rst = 0; ExStall = 0; Reg1Data = 16'h0777;
    cyc();
    chk("post_valid", ExValid, 1);
    chk("post_reg1", ExReg1, 16'h0777);
    chk("post_ctrl", ExCtrl, 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
